// File: rtl/rf_access_arbiter_pkg.sv
// Shared definitions for the register-file access arbiter.
// Holds the access-type encodings, the lock limit used when RF_ARB_LOCK_EN
// is defined, and small index helpers shared by the arbiter and its picker.
package rf_access_arbiter_pkg;

  // Access type carried on req_we.
  localparam logic RF_ARB_OP_READ  = 1'b0;
  localparam logic RF_ARB_OP_WRITE = 1'b1;

  // Maximum consecutive grants a locked requester may hold.
  localparam int RF_ARB_LOCK_MAX = 8;
  localparam int RF_ARB_LOCK_CW  = 4;

  // LSB position of field idx in a packed vector of w-bit fields.
  function automatic int fld_lsb(input int idx, input int w);
    return idx * w;
  endfunction

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Circular distance from start to idx in a ring of n entries.
  function automatic int ring_dist(input int idx, input int start, input int n);
    return (idx + 2 * n - start) % n;
  endfunction

endpackage

// File: rtl/rf_access_arbiter_rr_priority_picker.sv
// Round-robin priority picker: the first set request at or after the pointer
// (wrapping) wins. Purely combinational so other arbiters can reuse it.
module rr_priority_picker
  import rf_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     winner,
  output logic               any
);

  // Pick the request with the smallest circular distance from the pointer.
  always_comb begin
    int best_d;
    int d;
    best_d = NUM_REQ;
    d      = 0;
    winner = '0;
    any    = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = ring_dist(j, int'(ptr), NUM_REQ);
      if (req[j] && d < best_d) begin
        best_d = d;
        winner = IDW'(j);
        any    = 1'b1;
      end
    end
    grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = any && (winner == IDW'(j));
    end
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Register-file access arbiter: round-robin sharing of one array port between
// NUM_REQ requesters, a registered array-drive stage and a registered read
// response stage. Optional macro RF_ARB_LOCK_EN adds req_lock, letting a
// granted requester keep priority for up to RF_ARB_LOCK_MAX grants.
module rf_access_arbiter
  import rf_access_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LENGTH  = 16,
  parameter int NUM_REQ = 3,
  localparam int AW  = $clog2(LENGTH),
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
`ifdef RF_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic [AW-1:0]            rf_addr,
  output logic                     rf_we,
  output logic [WIDTH-1:0]         rf_wdata,
  input  logic [WIDTH-1:0]         rf_rdata
);

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     winner;
  logic               any_req;
  logic               gnt;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [WIDTH-1:0]   sel_wdata;

  logic               vld_p1;
  logic               we_p1;
  logic [IDW-1:0]     id_p1;
  logic [AW-1:0]      addr_p1;
  logic [WIDTH-1:0]   wdata_p1;

  logic               vld_p2;
  logic [IDW-1:0]     id_p2;
  logic [WIDTH-1:0]   rdata_p2;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any_req)
  );

  // Grant is visible in the request cycle; nothing is granted while in reset.
  always_comb begin
    gnt       = any_req && !rst;
    req_ready = rst ? '0 : grant;
    sel_we    = req_we[winner];
    sel_addr  = req_addr[fld_lsb(int'(winner), AW) +: AW];
    sel_wdata = req_wdata[fld_lsb(int'(winner), WIDTH) +: WIDTH];
  end

`ifdef RF_ARB_LOCK_EN
  logic [RF_ARB_LOCK_CW-1:0] lock_cnt;
  logic [RF_ARB_LOCK_CW-1:0] lock_cnt_next;
  logic [RF_ARB_LOCK_CW-1:0] lock_base;
  logic                      lock_hold;
  logic                      lock_hold_next;

  // A locked winner keeps the pointer until its run reaches the lock limit.
  always_comb begin
    ptr_next       = IDW'(wrap_inc(int'(winner), NUM_REQ));
    lock_cnt_next  = '0;
    lock_hold_next = 1'b0;
    lock_base      = (lock_hold && winner == ptr) ? lock_cnt : '0;
    if (gnt && req_lock[winner] &&
        lock_base < RF_ARB_LOCK_CW'(RF_ARB_LOCK_MAX - 1)) begin
      ptr_next       = winner;
      lock_cnt_next  = lock_base + 1'b1;
      lock_hold_next = 1'b1;
    end
  end

  // Lock run tracking; cleared whenever a cycle passes without a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt  <= '0;
      lock_hold <= 1'b0;
    end else begin
      lock_cnt  <= lock_cnt_next;
      lock_hold <= lock_hold_next;
    end
  end
`else
  // Pure round-robin: advance past the winner.
  always_comb begin
    ptr_next = IDW'(wrap_inc(int'(winner), NUM_REQ));
  end
`endif

  // Round-robin pointer; holds when nobody is requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt) begin
      ptr <= ptr_next;
    end
  end

  // Stage 1: register the winning access and drive the array port.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      we_p1    <= RF_ARB_OP_READ;
      id_p1    <= '0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= gnt;
      if (gnt) begin
        we_p1    <= sel_we;
        id_p1    <= winner;
        addr_p1  <= sel_addr;
        wdata_p1 <= sel_wdata;
      end
    end
  end

  always_comb begin
    rf_addr  = addr_p1;
    rf_wdata = wdata_p1;
    rf_we    = vld_p1 && (we_p1 == RF_ARB_OP_WRITE);
  end

  // Stage 2: capture asynchronous read data for a valid read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      id_p2    <= '0;
      rdata_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1 && (we_p1 == RF_ARB_OP_READ);
      if (vld_p1 && (we_p1 == RF_ARB_OP_READ)) begin
        id_p2    <= id_p1;
        rdata_p2 <= rf_rdata;
      end
    end
  end

  always_comb begin
    rsp_valid = vld_p2;
    rsp_id    = id_p2;
    rsp_rdata = rdata_p2;
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: directed stimulus, a register array driven by
// the DUT port, a transaction-level reference model checked every cycle, and
// literal expectations for the key scenarios.
module tb_rf_access_arbiter;
  localparam int WIDTH   = 32;
  localparam int LENGTH  = 16;
  localparam int NUM_REQ = 3;
  localparam int AW      = 4;
  localparam int IDW     = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*AW-1:0]    req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
`ifdef RF_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock;
`endif
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_rdata;
  logic [AW-1:0]            rf_addr;
  logic                     rf_we;
  logic [WIDTH-1:0]         rf_wdata;
  logic [WIDTH-1:0]         rf_rdata;

  int total = 0;
  int bad   = 0;

  rf_access_arbiter #(.WIDTH(WIDTH), .LENGTH(LENGTH), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef RF_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rf_addr   (rf_addr),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata)
  );

  always #5 clk = ~clk;

  // Register array seen by the DUT: async read, write at the clock edge.
  logic [WIDTH-1:0] mem [LENGTH];
  logic             load;
  assign rf_rdata = mem[rf_addr];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < LENGTH; i++) mem[i] <= WIDTH'(i * 3);
    end else if (rf_we) begin
      mem[rf_addr] <= rf_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: grants, array accesses and responses as transactions.
  bit               model_en = 1'b0;
  bit               model_init = 1'b0;
  logic [WIDTH-1:0] mref [LENGTH];
  int               m_ptr;
  bit               s1_vld, s1_we;
  int               s1_id, s1_addr;
  logic [WIDTH-1:0] s1_wdata;
  int               m_addr;
  logic [WIDTH-1:0] m_wdata;
  bit               m_rv;
  int               m_rid;
  logic [WIDTH-1:0] m_rdata;
  int               m_owner, m_run;

  always @(negedge clk) begin
    if (model_en) begin
      int w;
      int n;
      logic [NUM_REQ-1:0] exp_ready;
      if (!model_init) begin
        for (int i = 0; i < LENGTH; i++) mref[i] = WIDTH'(i * 3);
        m_ptr = 0; s1_vld = 0; s1_we = 0; s1_id = 0; s1_addr = 0; s1_wdata = '0;
        m_addr = 0; m_wdata = '0; m_rv = 0; m_rid = 0; m_rdata = '0;
        m_owner = -1; m_run = 0;
        model_init = 1'b1;
      end
      w = -1;
      exp_ready = '0;
      if (!rst) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (w < 0 && req_valid[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
        end
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      chk("m_ready", req_ready, exp_ready);
      chk("m_rf_we", rf_we, s1_vld && s1_we);
      chk("m_rf_addr", rf_addr, m_addr);
      chk("m_rf_wdata", rf_wdata, m_wdata);
      chk("m_rsp_valid", rsp_valid, m_rv);
      chk("m_rsp_id", rsp_id, m_rid);
      chk("m_rsp_rdata", rsp_rdata, m_rdata);
      if (rst) begin
        m_ptr = 0; s1_vld = 0; s1_we = 0; m_addr = 0; m_wdata = '0;
        m_rv = 0; m_rid = 0; m_rdata = '0; m_owner = -1; m_run = 0;
      end else begin
        m_rv = 0;
        if (s1_vld && !s1_we) begin
          m_rv = 1; m_rid = s1_id; m_rdata = mref[s1_addr];
        end
        if (s1_vld && s1_we) mref[s1_addr] = s1_wdata;
        s1_vld = (w >= 0);
        if (w >= 0) begin
          s1_we    = req_we[w];
          s1_id    = w;
          s1_addr  = int'(req_addr[w*AW +: AW]);
          s1_wdata = req_wdata[w*WIDTH +: WIDTH];
          m_addr   = s1_addr;
          m_wdata  = s1_wdata;
          n = (w == m_owner) ? m_run + 1 : 1;
`ifdef RF_ARB_LOCK_EN
          if (req_lock[w] && n < 8) begin
            m_ptr = w; m_owner = w; m_run = n;
          end else begin
            m_ptr = (w + 1) % NUM_REQ; m_owner = -1; m_run = 0;
          end
`else
          m_ptr = (w + 1) % NUM_REQ; m_owner = -1; m_run = n - n;
`endif
        end else begin
          m_owner = -1; m_run = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic drv(input int i, input logic we, input int addr, input logic [WIDTH-1:0] wd);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*WIDTH +: WIDTH] = wd;
  endtask

  logic [NUM_REQ-1:0] seen [12];
  logic [NUM_REQ-1:0] rr_exp [6];

  initial begin
    rst = 1'b1; load = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef RF_ARB_LOCK_EN
    req_lock = '0;
`endif
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

    // Reset held 3 cycles with every requester asking.
    cyc();
    load = 1'b0;
    model_en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) drv(i, 1'b0, i + 4, '0);
    chk("reset_ready", req_ready, 3'b000);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("post_reset_rf_we", rf_we, 1'b0);
    chk("post_reset_rsp_valid", rsp_valid, 1'b0);

    // Round-robin with all requesters busy.
    for (int k = 0; k < 6; k++) begin
      seen[k] = req_ready;
      cyc();
      #1;
    end
    for (int k = 0; k < 6; k++) chk($sformatf("rr_grant%0d", k), seen[k], rr_exp[k]);
    idle();
    cyc(); cyc(); cyc();

    // Write addr 5, then read it back from another requester.
    drv(0, 1'b1, 5, 32'hDEADBEEF);
    cyc();
    idle();
    drv(1, 1'b0, 5, '0);
    #1;
    chk("wr_rf_we", rf_we, 1'b1);
    chk("wr_rf_addr", rf_addr, 4'd5);
    cyc();
    idle();
    cyc();
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_id", rsp_id, 2'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    cyc(); cyc();

    // Back-to-back reads from requester 2.
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 4) drv(2, 1'b0, k, '0);
      #1;
      if (k >= 2) begin
        chk($sformatf("b2b_valid%0d", k - 2), rsp_valid, 1'b1);
        chk($sformatf("b2b_id%0d", k - 2), rsp_id, 2'd2);
        chk($sformatf("b2b_rdata%0d", k - 2), rsp_rdata, 32'((k - 2) * 3));
      end
      cyc();
    end
    idle();
    cyc(); cyc();

    // Reset while a read is in flight.
    drv(1, 1'b0, 1, '0);
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("flush_rsp_valid0", rsp_valid, 1'b0);
    chk("flush_rf_we", rf_we, 1'b0);
    cyc();
    chk("flush_rsp_valid1", rsp_valid, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) drv(i, 1'b0, i, '0);
    #1;
    chk("flush_ptr_zero", req_ready, 3'b001);
    cyc();
    idle();
    cyc(); cyc(); cyc();

`ifdef RF_ARB_LOCK_EN
    // Locked requester 0 competing with requester 1.
    req_lock = 3'b001;
    drv(0, 1'b0, 2, '0);
    drv(1, 1'b0, 3, '0);
    for (int k = 0; k < 9; k++) begin
      #1;
      seen[k] = req_ready;
      cyc();
    end
    for (int k = 0; k < 8; k++) chk($sformatf("lock_grant%0d", k), seen[k], 3'b001);
    chk("lock_release", seen[8], 3'b010);
    req_lock = '0;
    idle();
    cyc(); cyc(); cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
